// File: rtl/regread_stage_if.sv
// Instruction, register-bank, writeback and execute-side signals of the operand-fetch stage.
// The slave modport is the stage itself; master is its environment.
interface regread_stage_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_sr1;
  logic [AW-1:0]   in_sr2;
  logic [AW-1:0]   in_dr;
  logic            in_we;
  logic [AW-1:0]   rf_sr1;
  logic [AW-1:0]   rf_sr2;
  logic [DW-1:0]   rf_rdData1;
  logic [DW-1:0]   rf_rdData2;
  logic            wb_valid;
  logic [AW-1:0]   wb_dr;
  logic [DW-1:0]   wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_op1;
  logic [DW-1:0]   out_op2;
  logic [AW-1:0]   out_dr;
  logic            out_we;
  logic [NREG-1:0] busy;

  modport slave (
    input  in_valid, in_sr1, in_sr2, in_dr, in_we,
    input  rf_rdData1, rf_rdData2,
    input  wb_valid, wb_dr, wb_data,
    input  out_ready,
    output in_ready, rf_sr1, rf_sr2,
    output out_valid, out_op1, out_op2, out_dr, out_we, busy
  );

  modport master (
    output in_valid, in_sr1, in_sr2, in_dr, in_we,
    output rf_rdData1, rf_rdData2,
    output wb_valid, wb_dr, wb_data,
    output out_ready,
    input  in_ready, rf_sr1, rf_sr2,
    input  out_valid, out_op1, out_op2, out_dr, out_we, busy
  );
endinterface

// File: rtl/regread_stage.sv
// Operand-fetch stage: drives bank read addresses, captures operands with writeback
// bypass into a one-entry output register, and stalls on RAW/WAW via a busy scoreboard.
module regread_stage #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             reset,
  regread_stage_if.slave   bus
);

  logic [NREG-1:0] r_busy;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_op1;
  logic [DW-1:0]   r_out_op2;
  logic [AW-1:0]   r_out_dr;
  logic            r_out_we;

  logic [AW-1:0]   w_sr1;
  logic [AW-1:0]   w_sr2;
  logic [AW-1:0]   w_dr;
  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_eb;
  logic            w_hz;
  logic            w_in_ready;
  logic            w_acc;
  logic [DW-1:0]   w_op1;
  logic [DW-1:0]   w_op2;

  assign w_sr1 = bus.in_sr1;
  assign w_sr2 = bus.in_sr2;
  assign w_dr  = bus.in_dr;

  always_comb begin
    w_wb_mask = '0;
    if (bus.wb_valid) w_wb_mask[bus.wb_dr] = 1'b1;
  end

  // A writeback in this cycle already resolves the hazard on its register.
  assign w_eb       = r_busy & ~w_wb_mask;
  assign w_hz       = w_eb[w_sr1] | w_eb[w_sr2] | (bus.in_we & w_eb[w_dr]);
  assign w_in_ready = reset & ~w_hz & (~r_out_valid | bus.out_ready);
  assign w_acc      = bus.in_valid & w_in_ready;

  always_comb begin
    w_set_mask = '0;
    if (w_acc && bus.in_we) w_set_mask[w_dr] = 1'b1;
  end

  // The bank writes at the same edge we sample, so a matching writeback must be forwarded.
  assign w_op1 = (bus.wb_valid && (bus.wb_dr == w_sr1)) ? bus.wb_data : bus.rf_rdData1;
  assign w_op2 = (bus.wb_valid && (bus.wb_dr == w_sr2)) ? bus.wb_data : bus.rf_rdData2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_out_op1   <= '0;
      r_out_op2   <= '0;
      r_out_dr    <= '0;
      r_out_we    <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_wb_mask) | w_set_mask;
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_op1   <= w_op1;
        r_out_op2   <= w_op2;
        r_out_dr    <= w_dr;
        r_out_we    <= bus.in_we;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rf_sr1    = w_sr1;
  assign bus.rf_sr2    = w_sr2;
  assign bus.out_valid = r_out_valid;
  assign bus.out_op1   = r_out_op1;
  assign bus.out_op2   = r_out_op2;
  assign bus.out_dr    = r_out_dr;
  assign bus.out_we    = r_out_we;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_regread_stage.sv
// Bench for regread_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the stage and bank.
module tb_regread_stage;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic clk;
  logic reset;
  regread_stage_if #(.DW(DW), .AW(AW), .NREG(NREG)) bus ();

  regread_stage #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] bank [NREG];
  assign bus.rf_rdData1 = bank[bus.rf_sr1];
  assign bus.rf_rdData2 = bank[bus.rf_sr2];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: set of pending destination registers and the one-entry output slot.
  bit          pend [NREG];
  bit          m_valid;
  bit [DW-1:0] m_op1, m_op2;
  int          m_dr;
  bit          m_we;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit still_pending(input int r);
    return pend[r] && !(bus.wb_valid && int'(bus.wb_dr) == r);
  endfunction

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] v;
    for (int unsigned i = 0; i < NREG; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic bit [DW-1:0] fetch(input int r);
    if (bus.wb_valid && int'(bus.wb_dr) == r) return bus.wb_data;
    return bank[r];
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < NREG; i++) pend[i] = 0;
    m_valid = 0; m_op1 = '0; m_op2 = '0; m_dr = 0; m_we = 0;
  endtask

  // Inputs must already be driven; called just after a falling edge.
  task automatic tick();
    bit exp_ready, acc, n_valid, n_we;
    bit [DW-1:0] n_op1, n_op2;
    int n_dr;
    bit n_pend [NREG];
    #1;
    exp_ready = reset && !(still_pending(int'(bus.in_sr1)) || still_pending(int'(bus.in_sr2)) ||
                           (bus.in_we && still_pending(int'(bus.in_dr))))
                && (!m_valid || bus.out_ready);
    chk("in_ready", bus.in_ready, exp_ready);
    acc = bus.in_valid && exp_ready;
    n_valid = m_valid; n_op1 = m_op1; n_op2 = m_op2; n_dr = m_dr; n_we = m_we;
    n_pend = pend;
    if (bus.wb_valid) n_pend[bus.wb_dr] = 0;
    if (acc && bus.in_we) n_pend[bus.in_dr] = 1;
    if (acc) begin
      n_valid = 1; n_op1 = fetch(int'(bus.in_sr1)); n_op2 = fetch(int'(bus.in_sr2));
      n_dr = int'(bus.in_dr); n_we = bus.in_we;
    end else if (bus.out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else begin
      pend = n_pend; m_valid = n_valid; m_op1 = n_op1; m_op2 = n_op2; m_dr = n_dr; m_we = n_we;
    end
    if (bus.wb_valid) bank[bus.wb_dr] = bus.wb_data;
    chk("out_valid", bus.out_valid, m_valid);
    chk("busy", bus.busy, model_busy());
    if (m_valid || !reset) begin
      chk("out_op1", bus.out_op1, m_op1);
      chk("out_op2", bus.out_op2, m_op2);
      chk("out_dr", bus.out_dr, m_dr[AW-1:0]);
      chk("out_we", bus.out_we, m_we);
    end
    @(negedge clk);
  endtask

  task automatic issue(input bit v, input int s1, input int s2, input int d, input bit we);
    bus.in_valid = v; bus.in_sr1 = s1[AW-1:0]; bus.in_sr2 = s2[AW-1:0];
    bus.in_dr = d[AW-1:0]; bus.in_we = we;
  endtask

  task automatic wb(input bit v, input int d, input logic [DW-1:0] data);
    bus.wb_valid = v; bus.wb_dr = d[AW-1:0]; bus.wb_data = data;
  endtask

  initial begin
    int q [$];
    for (int i = 0; i < NREG; i++) bank[i] = '0;
    model_reset();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, '0);

    // Reset then idle
    tick(); tick();
    reset = 1'b1;
    #1 chk("idle_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("idle_busy", bus.busy, 32'h0);
    chk("idle_out_valid", bus.out_valid, 1'b0);

    // Simple fetch
    bank[3] = 32'h11; bank[4] = 32'h22; bank[1] = 32'h1111; bank[2] = 32'h2222;
    issue(1, 3, 4, 5, 1);
    tick();
    chk("fetch_op1", bus.out_op1, 32'h11);
    chk("fetch_op2", bus.out_op2, 32'h22);
    chk("fetch_dr", bus.out_dr, 5);
    chk("fetch_busy5", bus.busy[5], 1'b1);

    // RAW stall, then release by same-cycle writeback with bypass
    issue(1, 5, 0, 6, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", bus.in_ready, 1'b0);
      tick();
    end
    wb(1, 5, 32'hDEAD);
    #1 chk("raw_release", bus.in_ready, 1'b1);
    tick();
    chk("raw_bypass_op1", bus.out_op1, 32'hDEAD);
    chk("raw_busy5", bus.busy[5], 1'b0);
    wb(0, 0, '0);

    // WAW with writeback to the same register: set wins
    issue(1, 0, 0, 7, 1);
    tick();
    chk("waw_busy7_set", bus.busy[7], 1'b1);
    wb(1, 7, 32'h77);
    #1 chk("waw_accept", bus.in_ready, 1'b1);
    tick();
    chk("waw_busy7_kept", bus.busy[7], 1'b1);
    issue(0, 0, 0, 0, 0);
    tick();
    wb(0, 0, '0);
    tick();

    // Backpressure holds the output and blocks new instructions
    bus.out_ready = 1'b0;
    issue(1, 1, 2, 10, 1);
    tick();
    issue(1, 3, 4, 11, 1);
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp_stall", bus.in_ready, 1'b0);
      tick();
      chk("bp_hold_op1", bus.out_op1, 32'h1111);
      chk("bp_hold_dr", bus.out_dr, 10);
      chk("bp_busy", bus.busy, 32'h0000_0400);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_second_dr", bus.out_dr, 11);
    chk("bp_second_op2", bus.out_op2, 32'h22);
    issue(0, 0, 0, 0, 0);
    tick();

    // Reset mid-operation
    bus.out_ready = 1'b0;
    issue(1, 0, 0, 9, 1);
    tick();
    chk("mid_busy9", bus.busy[9], 1'b1);
    issue(0, 0, 0, 0, 0);
    reset = 1'b0;
    #1 chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    tick();
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 32'h0);
    chk("mid_rst_op1", bus.out_op1, 32'h0);
    reset = 1'b1;

    // Randomized traffic; writebacks mostly target pending registers
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      issue($urandom_range(0, 9) < 7, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
            $urandom_range(0, NREG - 1), $urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < NREG; i++) if (pend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 4)
        wb(1, q[$urandom_range(0, q.size() - 1)], $urandom);
      else if ($urandom_range(0, 9) == 0)
        wb(1, $urandom_range(0, NREG - 1), $urandom);
      else
        wb(0, $urandom_range(0, NREG - 1), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
